// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
//============================================================================
// Module : mux4_rr_arbiter_if
// Brief  : Request/data/grant bundle between four requesters and the
//          round-robin arbiter in front of the 4:1 mux.
// Rev    : 1.0  initial release
//============================================================================
interface mux4_rr_arbiter_if #(
   parameter int DATA_W = 1
);
   logic [3:0]        req;
   logic [DATA_W-1:0] i0;
   logic [DATA_W-1:0] i1;
   logic [DATA_W-1:0] i2;
   logic [DATA_W-1:0] i3;
   logic [3:0]        gnt;
   logic [1:0]        sel;
   logic              busy;
   logic [DATA_W-1:0] out;

   // Requester side
   modport master (
      output req, i0, i1, i2, i3,
      input  gnt, sel, busy, out
   );

   // Arbiter side
   modport slave (
      input  req, i0, i1, i2, i3,
      output gnt, sel, busy, out
   );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
//============================================================================
// Module : mux4_rr_arbiter
// Brief  : Round-robin arbiter/sequencer driving the 4:1 mux select, one-hot
//          grant and the forwarded output. Optional macro
//          MUX4_ARB_TIMEOUT_EN forces rotation after HOLD_MAX grant cycles.
// Rev    : 1.0  initial release
//============================================================================
module mux4_rr_arbiter #(
   parameter int DATA_W   = 1,
   parameter int HOLD_MAX = 8
) (
   input  logic               clk,
   input  logic               rst,
   mux4_rr_arbiter_if.slave   bus
);

   localparam int HC_W = $clog2(HOLD_MAX + 1);
   localparam logic [HC_W-1:0] C_HOLD_MAX = HC_W'(HOLD_MAX);
   localparam logic [HC_W-1:0] C_HOLD_ONE = HC_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      last_q, last_d;
   logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [3:0]        w_sel_onehot;
   logic              w_busy;
   logic              w_any_req;
   logic [1:0]        w_idle_win;
   logic [1:0]        w_next_win;
   logic [DATA_W-1:0] w_mux;

   // First set bit of r searching upward from start, wrapping 3->0.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] idx;
      logic       found;
      rr_pick = start;
      found   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = start + 2'(k);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign w_sel_onehot = 4'b0001 << sel_q;
   assign w_busy       = (state_q == ST_GRANT);
   assign w_any_req    = |bus.req;
   assign w_idle_win   = rr_pick(bus.req, last_q + 2'd1);
   // Current owner masked so a forced rotation never lands back on it.
   assign w_next_win   = rr_pick(bus.req & ~w_sel_onehot, sel_q + 2'd1);

`ifdef MUX4_ARB_TIMEOUT_EN
   logic w_others_pending;
   assign w_others_pending = |(bus.req & ~w_sel_onehot);
`endif

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (w_any_req) begin
               state_d    = ST_GRANT;
               sel_d      = w_idle_win;
               last_d     = w_idle_win;
               hold_cnt_d = C_HOLD_ONE;
            end
         end
         ST_GRANT: begin
            if (!bus.req[sel_q]) begin
               if (w_any_req) begin
                  sel_d      = w_next_win;
                  last_d     = w_next_win;
                  hold_cnt_d = C_HOLD_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
`ifdef MUX4_ARB_TIMEOUT_EN
            end else if ((hold_cnt_q == C_HOLD_MAX) && w_others_pending) begin
               sel_d      = w_next_win;
               last_d     = w_next_win;
               hold_cnt_d = C_HOLD_ONE;
`endif
            end else if (hold_cnt_q != C_HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + C_HOLD_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= 2'd0;
         last_q     <= 2'd3;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      w_mux = bus.i0;
      case (sel_q)
         2'd0:    w_mux = bus.i0;
         2'd1:    w_mux = bus.i1;
         2'd2:    w_mux = bus.i2;
         default: w_mux = bus.i3;
      endcase
   end

   assign bus.gnt  = w_busy ? w_sel_onehot : 4'b0000;
   assign bus.sel  = sel_q;
   assign bus.busy = w_busy;
   assign bus.out  = w_busy ? w_mux : '0;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_mux4_rr_arbiter
// Brief  : Self-checking bench: directed scenarios plus random traffic
//          compared against a behavioural round-robin reference model.
// Rev    : 1.0  initial release
//============================================================================
module tb_mux4_rr_arbiter;

   localparam int DATA_W   = 4;
   localparam int HOLD_MAX = 8;

   logic clk;
   logic rst;

   int n_checks;
   int n_fails;

   mux4_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

   mux4_rr_arbiter #(
      .DATA_W   (DATA_W),
      .HOLD_MAX (HOLD_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, kept as plain integers
   int m_busy;
   int m_sel;
   int m_last;
   int m_hold;
   logic [DATA_W-1:0] d [4];

   function automatic int first_from(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic r, input logic [3:0] rq);
      int w;
      logic [3:0] others;
      if (r) begin
         m_busy = 0; m_sel = 0; m_last = 3; m_hold = 0;
      end else if (m_busy == 0) begin
         w = first_from(rq, (m_last + 1) % 4);
         if (w >= 0) begin
            m_busy = 1; m_sel = w; m_last = w; m_hold = 1;
         end
      end else if (!rq[m_sel]) begin
         w = first_from(rq, (m_sel + 1) % 4);
         if (w >= 0) begin
            m_sel = w; m_last = w; m_hold = 1;
         end else begin
            m_busy = 0;
         end
      end else begin
         others = rq;
         others[m_sel] = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
         if (m_hold == HOLD_MAX && others != 4'b0000) begin
            w = first_from(others, (m_sel + 1) % 4);
            m_sel = w; m_last = w; m_hold = 1;
         end else if (m_hold < HOLD_MAX) begin
            m_hold = m_hold + 1;
         end
`else
         if (m_hold < HOLD_MAX) m_hold = m_hold + 1;
`endif
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model across the edge, compare every output.
   task automatic step(input logic r, input logic [3:0] rq);
      logic [3:0]        e_gnt;
      logic [DATA_W-1:0] e_out;
      @(negedge clk);
      rst     = r;
      bus.req = rq;
      bus.i0  = d[0];
      bus.i1  = d[1];
      bus.i2  = d[2];
      bus.i3  = d[3];
      model_edge(r, rq);
      @(posedge clk);
      #1;
      e_gnt = (m_busy != 0) ? (4'b0001 << m_sel) : 4'b0000;
      e_out = (m_busy != 0) ? d[m_sel] : '0;
      chk("model_gnt",  32'(bus.gnt),  32'(e_gnt));
      chk("model_sel",  32'(bus.sel),  32'(m_sel));
      chk("model_busy", 32'(bus.busy), 32'(m_busy));
      chk("model_out",  32'(bus.out),  32'(e_out));
   endtask

   initial begin
      logic [3:0] rq;
      int         cur;
      n_checks = 0;
      n_fails  = 0;
      rst      = 1'b1;
      bus.req  = 4'b0000;
      bus.i0   = '0;
      bus.i1   = '0;
      bus.i2   = '0;
      bus.i3   = '0;
      for (int n = 0; n < 4; n++) d[n] = DATA_W'(n + 5);
      m_busy = 0; m_sel = 0; m_last = 3; m_hold = 0;

      // Reset held with all requests pending
      step(1'b1, 4'b1111);
      step(1'b1, 4'b1111);
      chk("rst_gnt",  32'(bus.gnt),  32'h0);
      chk("rst_sel",  32'(bus.sel),  32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_out",  32'(bus.out),  32'h0);
      step(1'b0, 4'b1111);
      chk("first_gnt", 32'(bus.gnt), 32'h1);

      // Single requester on input 2
      step(1'b1, 4'b0000);
      d[0] = '0; d[1] = '0; d[2] = DATA_W'(1); d[3] = '0;
      step(1'b0, 4'b0100);
      chk("single_gnt", 32'(bus.gnt), 32'h4);
      chk("single_sel", 32'(bus.sel), 32'h2);
      chk("single_out", 32'(bus.out), 32'h1);
      step(1'b0, 4'b0000);
      chk("single_rel_busy", 32'(bus.busy), 32'h0);
      chk("single_rel_gnt",  32'(bus.gnt),  32'h0);
      chk("single_rel_out",  32'(bus.out),  32'h0);
      chk("single_rel_sel",  32'(bus.sel),  32'h2);

      // Round robin: each owner drops its request for one cycle
      for (int n = 0; n < 4; n++) d[n] = DATA_W'(4'hA + n);
      step(1'b1, 4'b0000);
      step(1'b0, 4'b1111);
      cur = 0;
      chk("rr_grant0", 32'(bus.sel), 32'h0);
      for (int g = 1; g <= 4; g++) begin
         rq = 4'b1111;
         rq[cur] = 1'b0;
         step(1'b0, rq);
         cur = g % 4;
         chk("rr_order", 32'(bus.sel), 32'(cur));
         chk("rr_nobubble", 32'(bus.busy), 32'h1);
      end

      // Wrap and skip from last=3
      step(1'b1, 4'b0000);
      step(1'b0, 4'b1010);
      chk("skip_gnt1", 32'(bus.gnt), 32'h2);
      step(1'b0, 4'b1000);
      chk("skip_gnt3", 32'(bus.gnt), 32'h8);
      step(1'b0, 4'b0000);
      chk("skip_idle", 32'(bus.busy), 32'h0);

      // Fairness timeout with two steady requesters
      step(1'b1, 4'b0000);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 4'b0011);
`ifdef MUX4_ARB_TIMEOUT_EN
         chk("timeout_gnt", 32'(bus.gnt), ((c / HOLD_MAX) % 2 == 0) ? 32'h1 : 32'h2);
`else
         chk("hold_gnt", 32'(bus.gnt), 32'h1);
`endif
      end

      // Reset in the middle of a grant
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0100);
      chk("mid_sel_pre", 32'(bus.sel), 32'h2);
      step(1'b1, 4'b0100);
      chk("mid_gnt",  32'(bus.gnt),  32'h0);
      chk("mid_busy", 32'(bus.busy), 32'h0);
      chk("mid_sel",  32'(bus.sel),  32'h0);
      step(1'b0, 4'b1111);
      chk("mid_first", 32'(bus.gnt), 32'h1);

      // Random traffic against the model
      rq = 4'b0000;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) rq = 4'($urandom);
         for (int n = 0; n < 4; n++) d[n] = DATA_W'($urandom);
         step(($urandom_range(40) == 0), rq);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
